// File: rtl/lsu_pkg.sv
// Shared load/store decode constants, FSM state type and access-size helper
// for the byte-lane strobe controller.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        WAIT0,
        BEAT1,
        WAIT1,
        RESP
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_strobe_ctrl_if.sv
// Core-side request/response bundle and memory-side beat bundle for the
// load/store strobe controller.
interface lsu_core_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_wstrb;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load-data extraction: shifts the two-beat window down by the byte offset,
// keeps the access size and sign- or zero-extends to XLEN.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]         beats,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [2:0]                funct3,
    output logic [XLEN-1:0]           rdata
);

    logic [3:0]      size;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] msb;
    logic            neg;

    always_comb begin
        size    = size_bytes(funct3);
        shifted = XLEN'(beats >> {off, 3'b000});
        // Full-width access shifts the 1 out entirely, leaving an all-ones mask.
        mask    = (XLEN'(1) << {size, 3'b000}) - XLEN'(1);
        low     = shifted & mask;
        msb     = mask ^ (mask >> 1);
        neg     = !funct3[2] && ((low & msb) != '0);
        rdata   = neg ? (low | ~mask) : low;
    end

endmodule

// File: rtl/lsu_strobe_ctrl.sv
// Load/store byte-lane controller: one outstanding request, one or two memory
// beats. Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses.
//
// state | meaning
// IDLE  | ready for a request
// BEAT0 | first memory beat offered
// WAIT0 | waiting for first beat read data
// BEAT1 | second beat offered (split builds only)
// WAIT1 | waiting for second beat read data (split builds only)
// RESP  | response held until the core takes it
module lsu_strobe_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    lsu_core_if.slave core,
    lsu_mem_if.master mem
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam int LANES = 2 * NB;
`else
    localparam int LANES = NB;
`endif
    localparam int DW = 8 * LANES;

    lsu_state_e        state_q, state_d;
    logic              we_q;
    logic              err_q;
    logic              split_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   beat0_q;

    logic [OFFW-1:0]   req_off;
    logic [3:0]        req_size;
    logic              req_legal;
    logic              req_err;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic              req_split;
    logic [XLEN-1:0]   beat1_q;
`endif

    always_comb begin
        req_off   = core.req_addr[OFFW-1:0];
        req_size  = size_bytes(core.req_funct3);
        req_legal = 1'b0;
        case (core.req_funct3)
            F3_B, F3_H, F3_W: req_legal = 1'b1;
            F3_D:             req_legal = (XLEN == 64);
            F3_BU, F3_HU:     req_legal = !core.req_we;
            F3_WU:            req_legal = !core.req_we && (XLEN == 64);
            default:          req_legal = 1'b0;
        endcase
`ifdef LSU_MISALIGNED_SPLIT_EN
        req_split = (4'(req_off) + req_size) > 4'(NB);
        req_err   = !req_legal;
`else
        req_err   = !req_legal || ((4'(req_off) & (req_size - 4'd1)) != 4'd0);
`endif
    end

    logic [OFFW-1:0]   off_q;
    logic [3:0]        size_q;
    logic [LANES-1:0]  strb_all;
    logic [DW-1:0]     wdata_all;
    logic [ADDR_W-1:0] base_addr;

    // Lane image spans two beats when splitting; beat 1 takes the upper half.
    always_comb begin
        off_q     = addr_q[OFFW-1:0];
        size_q    = size_bytes(f3_q);
        strb_all  = ((LANES'(1) << size_q) - LANES'(1)) << off_q;
        wdata_all = DW'(wdata_q) << {off_q, 3'b000};
        base_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    end

    logic [2*XLEN-1:0] beats;
    logic [XLEN-1:0]   load_data;

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign beats = {beat1_q, beat0_q};
`else
    assign beats = {{XLEN{1'b0}}, beat0_q};
`endif

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .beats  (beats),
        .off    (off_q),
        .funct3 (f3_q),
        .rdata  (load_data)
    );

    always_comb begin
        state_d         = state_q;
        core.req_ready  = 1'b0;
        core.resp_valid = 1'b0;
        core.resp_rdata = '0;
        core.resp_err   = 1'b0;
        mem.mem_valid   = 1'b0;
        mem.mem_we      = 1'b0;
        mem.mem_addr    = '0;
        mem.mem_wstrb   = '0;
        mem.mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                core.req_ready = !reset;
                if (core.req_valid) state_d = req_err ? RESP : BEAT0;
            end
            BEAT0: begin
                mem.mem_valid = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = base_addr;
                if (we_q) begin
                    mem.mem_wstrb = strb_all[NB-1:0];
                    mem.mem_wdata = wdata_all[XLEN-1:0];
                end
                if (mem.mem_ready) state_d = !we_q ? WAIT0 : (split_q ? BEAT1 : RESP);
            end
            WAIT0: begin
                if (mem.mem_rvalid) state_d = split_q ? BEAT1 : RESP;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            BEAT1: begin
                mem.mem_valid = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = base_addr + ADDR_W'(NB);
                if (we_q) begin
                    mem.mem_wstrb = strb_all[LANES-1:NB];
                    mem.mem_wdata = wdata_all[DW-1:XLEN];
                end
                if (mem.mem_ready) state_d = we_q ? RESP : WAIT1;
            end
            WAIT1: begin
                if (mem.mem_rvalid) state_d = RESP;
            end
`endif
            RESP: begin
                core.resp_valid = 1'b1;
                core.resp_err   = err_q;
                core.resp_rdata = (err_q || we_q) ? '0 : load_data;
                if (core.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && core.req_valid) begin
                we_q    <= core.req_we;
                err_q   <= req_err;
                f3_q    <= core.req_funct3;
                addr_q  <= core.req_addr;
                wdata_q <= core.req_wdata;
            end
            if (state_q == WAIT0 && mem.mem_rvalid) beat0_q <= mem.mem_rdata;
        end
    end

`ifdef LSU_MISALIGNED_SPLIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            split_q <= 1'b0;
            beat1_q <= '0;
        end else begin
            if (state_q == IDLE && core.req_valid) split_q <= req_split;
            if (state_q == WAIT1 && mem.mem_rvalid) beat1_q <= mem.mem_rdata;
        end
    end
`else
    assign split_q = 1'b0;
`endif

endmodule
